// File: rtl/seq_det_pkg.sv
// Shared types, default pattern constants and the round-robin pick function
// for the channel-shared serial pattern detector.
package seq_det_pkg;

  typedef enum logic [0:0] {RUN, FLUSH} sched_state_t;

  localparam int unsigned PAT_W_DEF = 4;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b1011;
  localparam int unsigned MaxCh = 16;

  // First valid channel searching from ptr+1, wrapping modulo n_ch.
  function automatic int unsigned rr_pick(input logic [MaxCh-1:0] valid,
                                          input int unsigned ptr,
                                          input int unsigned n_ch);
    int unsigned pick;
    int unsigned idx;
    logic found;
    logic [MaxCh-1:0] sh;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MaxCh; k++) begin
      idx = (ptr + k) % n_ch;
      sh  = valid >> idx;
      if (!found && (k <= n_ch) && sh[0]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/seq_det_ctx.sv
// One channel's detection context: bit history, fill count and match compare.
// With SEQ_DET_CNT_EN defined, also a saturating per-channel hit counter.
module seq_det_ctx #(
  parameter int unsigned PAT_W = 4,
  parameter logic [PAT_W-1:0] PATTERN = '0
`ifdef SEQ_DET_CNT_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic bit_i,
  input  logic clr_i,
  output logic hit_o
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] Full = FillW'(PAT_W);

  // The oldest bit is shifted out on the next load, so only PAT_W-1 bits are kept.
  logic [PAT_W-2:0] hist_q;
  logic [PAT_W-1:0] hist_d;
  logic [FillW-1:0] fill_q, fill_d;

  always_comb begin
    hist_d = {hist_q, bit_i};
    fill_d = (fill_q == Full) ? fill_q : fill_q + 1'b1;
    hit_o  = load_i && (hist_d == PATTERN) && (fill_d == Full);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (load_i) begin
      hist_q <= hist_d[PAT_W-2:0];
      fill_q <= fill_d;
    end
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (hit_o && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin sharing of one overlapping pattern detector across N_CH serial channels,
// with a sequenced context flush. SEQ_DET_CNT_EN adds per-channel hit counters (hit_cnt).
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF
`ifdef SEQ_DET_CNT_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         ch_valid,
  input  logic [N_CH-1:0]         ch_bit,
  output logic [N_CH-1:0]         ch_ready,
  input  logic                    flush_req,
  output logic                    flush_busy,
  output logic                    flush_done,
  output logic                    det_valid,
  output logic [$clog2(N_CH)-1:0] det_ch
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0]   hit_cnt
`endif
);

  localparam int unsigned ChW = $clog2(N_CH);
  localparam logic [ChW-1:0] LastCh = ChW'(N_CH - 1);

  sched_state_t   state_q, state_d;
  logic [ChW-1:0] ptr_q, ptr_d;
  logic [ChW-1:0] flush_idx_q, flush_idx_d;
  logic [ChW-1:0] grant;
  logic           flush_done_d;
  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] clr;
  int unsigned    pick;

  // Flush request blocks any same-cycle transfer.
  always_comb begin
    pick     = rr_pick(MaxCh'(ch_valid), 32'(ptr_q), N_CH);
    grant    = ChW'(pick);
    ch_ready = '0;
    if ((state_q == RUN) && !flush_req && (|ch_valid)) begin
      ch_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    flush_idx_d  = flush_idx_q;
    flush_done_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (|ch_ready) ptr_d = grant;
        if (flush_req) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      FLUSH: begin
        flush_idx_d = flush_idx_q + 1'b1;
        if (flush_idx_q == LastCh) begin
          state_d      = RUN;
          ptr_d        = LastCh;
          flush_idx_d  = '0;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ctx
    assign clr[i] = (state_q == FLUSH) && (flush_idx_q == ChW'(i));

    seq_det_ctx #(
      .PAT_W  (PAT_W),
`ifdef SEQ_DET_CNT_EN
      .CNT_W  (CNT_W),
`endif
      .PATTERN(PATTERN)
    ) u_ctx (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (ch_ready[i]),
      .bit_i  (ch_bit[i]),
      .clr_i  (clr[i]),
      .hit_o  (hit[i])
`ifdef SEQ_DET_CNT_EN
      ,
      .cnt_o  (hit_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ptr_q       <= LastCh;
      flush_idx_q <= '0;
      det_valid   <= 1'b0;
      det_ch      <= '0;
      flush_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      flush_idx_q <= flush_idx_d;
      det_valid   <= |hit;
      if (|ch_ready) det_ch <= grant;
      flush_done  <= flush_done_d;
    end
  end

  assign flush_busy = (state_q == FLUSH);

endmodule
